// File: rtl/udma_event_collector_if.sv
// Event-ID handshake between the collector and the consuming core.
// Master drives the queue head and the level interrupt; slave drives ready.
// A head is consumed on any cycle where evt_valid and evt_ready are both high.
interface udma_event_collector_if #(
    parameter int ID_WIDTH = 8
);
    logic                evt_valid;
    logic [ID_WIDTH-1:0] evt_id;
    logic                evt_ready;
    logic                irq;

    modport master (
        output evt_valid,
        output evt_id,
        output irq,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  irq,
        output evt_ready
    );
endinterface

// File: rtl/udma_event_collector.sv
// Masked edge detect of uDMA event lines, round-robin arbitration, event-ID queue.
// Latency: rising edge in cycle t -> pending end of t -> push in t+1 -> head valid in t+2.
// Backpressure: a full queue stalls grants; events wait in pending, only a re-edge on a pending bit is lost.
module udma_event_collector #(
    parameter int NUM_EVENTS = 132,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_EVENTS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_EVENTS-1:0]       events_i,
    input  logic [NUM_EVENTS-1:0]       mask_i,
    udma_event_collector_if.master      evt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        overflow_o,
    input  logic                        clr_overflow_i
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Edge detection and pending state
    logic [NUM_EVENTS-1:0] events_q;
    logic [NUM_EVENTS-1:0] pending_q, pending_d;
    logic [NUM_EVENTS-1:0] edge_v;
    logic [NUM_EVENTS-1:0] arb_req;
    logic                  lost;
    logic                  overflow_q, overflow_d;

    // Arbiter state
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic                  gnt_vld;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic [NUM_EVENTS-1:0] gnt_vec;

    // Queue state
    logic [ID_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop, can_push;

    assign edge_v  = events_i & ~events_q & mask_i;
    // A bit whose mask has just dropped must not win the arbiter on its way out.
    assign arb_req = pending_q & mask_i;

    assign pop      = evt.evt_valid & evt.evt_ready;
    assign can_push = (count_q < CNT_W'(FIFO_DEPTH)) | pop;
    assign push     = gnt_vld;

    // Round-robin search starting just after the last granted index, wrapping at NUM_EVENTS-1
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        for (int k = 1; k <= NUM_EVENTS; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_EVENTS) begin
                idx = idx - NUM_EVENTS;
            end
            if (!gnt_vld && can_push && arb_req[ID_WIDTH'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_WIDTH'(idx);
            end
        end
        if (gnt_vld) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    // Next-state for pending, overflow, arbiter pointer and occupancy
    always_comb begin
        // A fresh edge on a granted bit re-arms it; masked bits drop out.
        pending_d    = ((pending_q & ~gnt_vec) & mask_i) | edge_v;
        lost         = |(edge_v & pending_q & ~gnt_vec);
        overflow_d   = lost | (overflow_q & ~clr_overflow_i);
        last_grant_d = gnt_vld ? gnt_idx : last_grant_q;
        count_d      = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Event sampling, pending, overflow and arbiter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            events_q     <= '0;
            pending_q    <= '0;
            overflow_q   <= 1'b0;
            last_grant_q <= ID_WIDTH'(NUM_EVENTS - 1);
        end else begin
            events_q     <= events_i;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Circular event-ID queue; pointers wrap naturally because depth is a power of two
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= gnt_idx;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_id    = evt.evt_valid ? mem_q[rd_ptr_q] : '0;
    assign evt.irq       = evt.evt_valid;
    assign fifo_count_o  = count_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_udma_event_collector.sv
// Directed bench for udma_event_collector: latency, round-robin order, backpressure,
// overflow set/clear priority, masking and asynchronous reset.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
module tb_udma_event_collector;
    localparam int N  = 132;
    localparam int DP = 8;
    localparam int IW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [N-1:0]  events;
    logic [N-1:0]  mask;
    logic          clr_ovf;
    logic [3:0]    fifo_count;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    udma_event_collector_if #(.ID_WIDTH(IW)) evt_if ();

    udma_event_collector #(
        .NUM_EVENTS (N),
        .FIFO_DEPTH (DP),
        .ID_WIDTH   (IW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .events_i       (events),
        .mask_i         (mask),
        .evt            (evt_if.master),
        .fifo_count_o   (fifo_count),
        .overflow_o     (overflow),
        .clr_overflow_i (clr_ovf)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int exp_ids [9];

        rst_i            = 1'b1;
        events           = '0;
        mask             = '1;
        clr_ovf          = 1'b0;
        evt_if.evt_ready = 1'b0;
        #12;
        rst_i = 1'b0;
        #1;
        chk("rst_valid", 32'(evt_if.evt_valid), 0);
        chk("rst_id",    32'(evt_if.evt_id),    0);
        chk("rst_irq",   32'(evt_if.irq),       0);
        chk("rst_count", 32'(fifo_count),       0);
        chk("rst_ovf",   32'(overflow),         0);
        tick();

        // Single pulse on line 5: head appears two cycles after the pulse cycle
        events[5] = 1'b1;
        tick();
        events = '0;
        chk("t1_no_fallthru", 32'(evt_if.evt_valid), 0);
        tick();
        chk("t1_valid", 32'(evt_if.evt_valid), 1);
        chk("t1_id",    32'(evt_if.evt_id),    5);
        chk("t1_irq",   32'(evt_if.irq),       1);
        chk("t1_count", 32'(fifo_count),       1);
        evt_if.evt_ready = 1'b1;
        tick();
        chk("t1_popped_valid", 32'(evt_if.evt_valid), 0);
        chk("t1_popped_count", 32'(fifo_count),       0);

        // Round-robin from reset pointer (131): 3, 70, 131 then 3, 131
        do_reset();
        evt_if.evt_ready = 1'b1;
        events[3] = 1'b1; events[70] = 1'b1; events[131] = 1'b1;
        tick();
        events = '0;
        tick();
        chk("t2_id0", 32'(evt_if.evt_id), 3);
        tick();
        chk("t2_id1", 32'(evt_if.evt_id), 70);
        tick();
        chk("t2_id2", 32'(evt_if.evt_id), 131);
        tick();
        chk("t2_empty", 32'(evt_if.evt_valid), 0);
        events[3] = 1'b1; events[131] = 1'b1;
        tick();
        events = '0;
        tick();
        chk("t2_wrap_id0", 32'(evt_if.evt_id), 3);
        tick();
        chk("t2_wrap_id1", 32'(evt_if.evt_id), 131);
        tick();
        chk("t2_wrap_empty", 32'(evt_if.evt_valid), 0);

        // Backpressure: 10 events into an 8-deep queue, 2 wait in pending
        evt_if.evt_ready = 1'b0;
        for (int i = 20; i < 30; i++) events[i] = 1'b1;
        tick();
        events = '0;
        repeat (12) tick();
        chk("t3_full_count", 32'(fifo_count),    8);
        chk("t3_no_ovf",     32'(overflow),      0);
        chk("t3_head_hold",  32'(evt_if.evt_id), 20);
        evt_if.evt_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t3_drain_vld%0d", k), 32'(evt_if.evt_valid), 1);
            chk($sformatf("t3_drain_id%0d", k),  32'(evt_if.evt_id),    32'(20 + k));
            tick();
        end
        chk("t3_drained_vld", 32'(evt_if.evt_valid), 0);
        chk("t3_drained_cnt", 32'(fifo_count),       0);

        // Masked line never produces an event
        evt_if.evt_ready = 1'b0;
        mask[7]   = 1'b0;
        events[7] = 1'b1;
        tick();
        events = '0;
        repeat (3) tick();
        chk("t5_masked_vld", 32'(evt_if.evt_valid), 0);
        chk("t5_masked_cnt", 32'(fifo_count),       0);
        mask[7] = 1'b1;

        // Fill queue with 40..47, keep 12 pending, then re-edge 12 to lose an occurrence
        for (int i = 40; i < 48; i++) events[i] = 1'b1;
        events[12] = 1'b1;
        tick();
        events = '0;
        repeat (10) tick();
        chk("t4_full_count", 32'(fifo_count), 8);
        chk("t4_ovf_before", 32'(overflow),   0);
        events[12] = 1'b1;
        tick();
        events = '0;
        chk("t4_ovf_set", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 0);
        events[12] = 1'b1;
        clr_ovf    = 1'b1;
        tick();
        events  = '0;
        clr_ovf = 1'b0;
        chk("t4_set_wins", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t4_ovf_clr2", 32'(overflow), 0);

        // Line 7 goes pending while full, then is masked: must never appear
        events[7] = 1'b1;
        tick();
        events  = '0;
        mask[7] = 1'b0;
        tick();
        mask[7] = 1'b1;
        tick();
        chk("t5_full_hold", 32'(fifo_count), 8);
        for (int k = 0; k < 8; k++) exp_ids[k] = 40 + k;
        exp_ids[8] = 12;
        evt_if.evt_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t5_drain_vld%0d", k), 32'(evt_if.evt_valid), 1);
            chk($sformatf("t5_drain_id%0d", k),  32'(evt_if.evt_id),    32'(exp_ids[k]));
            tick();
        end
        chk("t5_drained_vld", 32'(evt_if.evt_valid), 0);

        // Asynchronous reset in the middle of a drain
        evt_if.evt_ready = 1'b0;
        for (int i = 50; i < 55; i++) events[i] = 1'b1;
        tick();
        events = '0;
        repeat (8) tick();
        chk("t6_count5", 32'(fifo_count), 5);
        evt_if.evt_ready = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(evt_if.evt_valid), 0);
        chk("t6_rst_id",    32'(evt_if.evt_id),    0);
        chk("t6_rst_irq",   32'(evt_if.irq),       0);
        chk("t6_rst_count", 32'(fifo_count),       0);
        chk("t6_rst_ovf",   32'(overflow),         0);
        events[2] = 1'b1;
        #2;
        rst_i = 1'b0;
        n = 0;
        repeat (8) begin
            tick();
            if (evt_if.evt_valid && evt_if.evt_id == 8'd2) n++;
        end
        chk("t6_id2_once", 32'(n), 1);
        chk("t6_final_cnt", 32'(fifo_count), 0);
        events = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
